fnd_scan_controller: RTL and testbench



---
 rtl/fnd_pkg.sv | 38 +++
 rtl/fnd_phase_timer.sv | 42 ++++
 rtl/fnd_scan_controller.sv | 212 +++++++++++++++++++++
 tb/tb_fnd_scan_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// ----------------------------------------------------------------------------
// fnd_pkg
//   Shared types and constants for the 4-digit FND scan path.
//   - fnd_state_t : scan FSM states (IDLE, ON, DEAD)
//   - FND_DIGITS  : number of multiplexed digits
//   - DIGIT_SEL_W : width of the digit index
//   - BCD_W       : width of one BCD digit
//   - lzb_mask()  : per-digit leading-zero blank flags for a packed value
// ----------------------------------------------------------------------------
package fnd_pkg;

   localparam int unsigned FND_DIGITS  = 4;
   localparam int unsigned DIGIT_SEL_W = 2;
   localparam int unsigned BCD_W       = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      DEAD = 2'd2
   } fnd_state_t;

   // Bit k set means digit k is a leading zero: it and every higher digit
   // are 0. Digit 0 is never flagged so an all-zero value still shows "0".
   function automatic logic [FND_DIGITS-1:0] lzb_mask(
      input logic [FND_DIGITS*BCD_W-1:0] value
   );
      logic [FND_DIGITS-1:0] mask;
      logic                  higher_zero;
      mask        = '0;
      higher_zero = 1'b1;
      for (int unsigned i = FND_DIGITS - 1; i >= 1; i--) begin
         higher_zero = higher_zero & (value[i*BCD_W +: BCD_W] == '0);
         mask[i]     = higher_zero;
      end
      return mask;
   endfunction

endpackage

// File: rtl/fnd_phase_timer.sv
// ----------------------------------------------------------------------------
// fnd_phase_timer
//   Loadable down-counter used to time both the lit (ON) and dark (DEAD)
//   phases of a scan slot. Loading N-1 gives a phase of exactly N cycles:
//   the counter walks N-1 .. 0 and flags terminal count while it sits at 0.
//   The counter stops at 0, so it can never underflow into a wrap glitch.
// Ports
//   i_Clk      in   system clock
//   i_Rst_n    in   asynchronous active-low reset (count -> 0)
//   i_Clear    in   synchronous clear to 0 (priority over load)
//   i_Load     in   load i_LoadVal
//   i_LoadVal  in   CNT_W  value to load (phase length - 1)
//   o_Tc       out  terminal count: counter is at 0
// ----------------------------------------------------------------------------
module fnd_phase_timer #(
   parameter int unsigned CNT_W = 17
) (
   input  logic             i_Clk,
   input  logic             i_Rst_n,
   input  logic             i_Clear,
   input  logic             i_Load,
   input  logic [CNT_W-1:0] i_LoadVal,
   output logic             o_Tc
);

   logic [CNT_W-1:0] r_Count;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Count <= '0;
      end else if (i_Clear) begin
         r_Count <= '0;
      end else if (i_Load) begin
         r_Count <= i_LoadVal;
      end else if (r_Count != '0) begin
         r_Count <= r_Count - 1'b1;
      end
   end

   assign o_Tc = (r_Count == '0);

endmodule

// File: rtl/fnd_scan_controller.sv
// ----------------------------------------------------------------------------
// fnd_scan_controller
//   Time-multiplexed scan driver for a 4-digit FND. Steps the active digit
//   0->1->2->3->0, lighting each for DIGIT_TICKS cycles followed by
//   DEAD_TICKS dark cycles (anti-ghosting). New values are staged in a
//   shadow register and only committed at the frame wrap (or while idle) so
//   a frame never shows a mix of old and new digits. Optional leading-zero
//   blanking darkens leading zero digits above digit 0.
// Parameters
//   DIGIT_TICKS  cycles each digit is lit per slot (>= 1)
//   DEAD_TICKS   dark cycles after each slot (0 = no dead-time)
//   CNT_W        phase counter width, holds max(DIGIT_TICKS,DEAD_TICKS)-1
// Ports
//   i_Clk          in   system clock
//   i_Rst_n        in   asynchronous active-low reset
//   i_Enable       in   1 = scanning, 0 = dark / IDLE
//   i_Load         in   1-cycle strobe capturing i_Value
//   i_Value        in   16  BCD digits, [3:0] = digit 0 (LSD)
//   i_LZB          in   leading-zero blanking enable
//   o_DigitSelect  out  2   active digit index
//   o_Blank        out  1 = all digits off
//   o_BCD          out  4   BCD code of the active digit
//   o_FrameDone    out  1-cycle pulse on the first lit cycle after a wrap
// ----------------------------------------------------------------------------
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int unsigned DIGIT_TICKS = 100000,
   parameter int unsigned DEAD_TICKS  = 1000,
   parameter int unsigned CNT_W       = 17
) (
   input  logic                         i_Clk,
   input  logic                         i_Rst_n,
   input  logic                         i_Enable,
   input  logic                         i_Load,
   input  logic [FND_DIGITS*BCD_W-1:0]  i_Value,
   input  logic                         i_LZB,
   output logic [DIGIT_SEL_W-1:0]       o_DigitSelect,
   output logic                         o_Blank,
   output logic [BCD_W-1:0]             o_BCD,
   output logic                         o_FrameDone
);

   localparam int unsigned VAL_W = FND_DIGITS * BCD_W;

   localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(DIGIT_TICKS - 1);
   localparam logic [CNT_W-1:0] DEAD_LOAD = (DEAD_TICKS == 0) ? '0
                                                              : CNT_W'(DEAD_TICKS - 1);
   localparam logic [DIGIT_SEL_W-1:0] LAST_DIGIT = DIGIT_SEL_W'(FND_DIGITS - 1);
   localparam logic [DIGIT_SEL_W-1:0] DIGIT_STEP = DIGIT_SEL_W'(1);

   // ------------------------------------------------------------------------
   // State and data registers
   // ------------------------------------------------------------------------
   fnd_state_t              r_State;
   logic [DIGIT_SEL_W-1:0]  r_Digit;
   logic [VAL_W-1:0]        r_Shadow;
   logic [VAL_W-1:0]        r_Active;
   logic                    r_Pending;
   logic                    r_Blank;
   logic [BCD_W-1:0]        r_Bcd;
   logic                    r_FrameDone;

   // ------------------------------------------------------------------------
   // Next-state / control wires
   // ------------------------------------------------------------------------
   fnd_state_t              w_NextState;
   logic [DIGIT_SEL_W-1:0]  w_NextDigit;
   logic                    w_TmrClear;
   logic                    w_TmrLoad;
   logic [CNT_W-1:0]        w_TmrLoadVal;
   logic                    w_Tc;
   logic                    w_Wrap;
   logic                    w_Commit;
   logic [VAL_W-1:0]        w_NextActive;
   logic [FND_DIGITS-1:0]   w_LzMask;
   logic                    w_NextBlank;
   logic [BCD_W-1:0]        w_NextBcd;

   fnd_phase_timer #(
      .CNT_W (CNT_W)
   ) u_phase_timer (
      .i_Clk     (i_Clk),
      .i_Rst_n   (i_Rst_n),
      .i_Clear   (w_TmrClear),
      .i_Load    (w_TmrLoad),
      .i_LoadVal (w_TmrLoadVal),
      .o_Tc      (w_Tc)
   );

   // ------------------------------------------------------------------------
   // Scan FSM. Every transition into a phase reloads the timer with that
   // phase's length - 1, so each phase lasts exactly its tick count.
   // ------------------------------------------------------------------------
   always_comb begin
      w_NextState  = r_State;
      w_NextDigit  = r_Digit;
      w_TmrClear   = 1'b0;
      w_TmrLoad    = 1'b0;
      w_TmrLoadVal = ON_LOAD;
      w_Wrap       = 1'b0;

      if (!i_Enable) begin
         w_NextState = IDLE;
         w_NextDigit = '0;
         w_TmrClear  = 1'b1;
      end else begin
         unique case (r_State)
            IDLE: begin
               // Start-up from idle is not a frame wrap: no FrameDone.
               w_NextState = ON;
               w_NextDigit = '0;
               w_TmrLoad   = 1'b1;
            end
            ON: begin
               if (w_Tc) begin
                  w_TmrLoad = 1'b1;
                  if (DEAD_TICKS == 0) begin
                     w_NextDigit = r_Digit + DIGIT_STEP;
                     w_Wrap      = (r_Digit == LAST_DIGIT);
                  end else begin
                     w_NextState  = DEAD;
                     w_TmrLoadVal = DEAD_LOAD;
                  end
               end
            end
            DEAD: begin
               if (w_Tc) begin
                  w_NextState = ON;
                  w_NextDigit = r_Digit + DIGIT_STEP;
                  w_TmrLoad   = 1'b1;
                  w_Wrap      = (r_Digit == LAST_DIGIT);
               end
            end
            default: begin
               w_NextState = IDLE;
               w_NextDigit = '0;
               w_TmrClear  = 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Tear-free commit: the active value only changes at a frame wrap or
   // while idle. A load on the commit cycle itself bypasses the shadow so
   // the newest value wins.
   // ------------------------------------------------------------------------
   assign w_Commit = (r_State == IDLE) | w_Wrap;

   always_comb begin
      w_NextActive = r_Active;
      if (w_Commit) begin
         if (i_Load) begin
            w_NextActive = i_Value;
         end else if (r_Pending) begin
            w_NextActive = r_Shadow;
         end
      end
   end

   // Outputs are computed from next-cycle state and data so that select,
   // blank, code and frame pulse all change on the same edge.
   assign w_LzMask    = lzb_mask(w_NextActive);
   assign w_NextBlank = (w_NextState != ON) | (i_LZB & w_LzMask[w_NextDigit]);

   always_comb begin
      w_NextBcd = '0;
      if (w_NextState != IDLE) begin
         w_NextBcd = w_NextActive[w_NextDigit*BCD_W +: BCD_W];
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_State     <= IDLE;
         r_Digit     <= '0;
         r_Shadow    <= '0;
         r_Active    <= '0;
         r_Pending   <= 1'b0;
         r_Blank     <= 1'b1;
         r_Bcd       <= '0;
         r_FrameDone <= 1'b0;
      end else begin
         r_State     <= w_NextState;
         r_Digit     <= w_NextDigit;
         r_Active    <= w_NextActive;
         r_Blank     <= w_NextBlank;
         r_Bcd       <= w_NextBcd;
         r_FrameDone <= w_Wrap;

         if (i_Load) begin
            r_Shadow <= i_Value;
         end

         if (w_Commit) begin
            r_Pending <= 1'b0;
         end else if (i_Load) begin
            r_Pending <= 1'b1;
         end
      end
   end

   assign o_DigitSelect = r_Digit;
   assign o_Blank       = r_Blank;
   assign o_BCD         = r_Bcd;
   assign o_FrameDone   = r_FrameDone;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_fnd_scan_controller
//   Directed bench for fnd_scan_controller with DIGIT_TICKS=4, DEAD_TICKS=2
//   (6-cycle slot, 24-cycle frame). Position p counts cycles from the first
//   lit cycle of a run: digit = (p%24)/6, dark when p%6 >= 4.
// ----------------------------------------------------------------------------
module tb_fnd_scan_controller;

   localparam int unsigned DT    = 4;
   localparam int unsigned DK    = 2;
   localparam int unsigned SLOT  = DT + DK;
   localparam int unsigned FRAME = 4 * SLOT;

   logic        i_Clk    = 1'b0;
   logic        i_Rst_n  = 1'b0;
   logic        i_Enable = 1'b0;
   logic        i_Load   = 1'b0;
   logic [15:0] i_Value  = '0;
   logic        i_LZB    = 1'b0;
   logic [1:0]  o_DigitSelect;
   logic        o_Blank;
   logic [3:0]  o_BCD;
   logic        o_FrameDone;

   int errors = 0;
   int checks = 0;

   logic [1:0]  e_sel;
   logic        e_blank;
   logic        e_fd;
   logic [3:0]  e_bcd;
   logic [15:0] e_val;

   always #5 i_Clk = ~i_Clk;

   fnd_scan_controller #(
      .DIGIT_TICKS (DT),
      .DEAD_TICKS  (DK),
      .CNT_W       (3)
   ) dut (
      .i_Clk         (i_Clk),
      .i_Rst_n       (i_Rst_n),
      .i_Enable      (i_Enable),
      .i_Load        (i_Load),
      .i_Value       (i_Value),
      .i_LZB         (i_LZB),
      .o_DigitSelect (o_DigitSelect),
      .o_Blank       (o_Blank),
      .o_BCD         (o_BCD),
      .o_FrameDone   (o_FrameDone)
   );

   task automatic step();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic stop_scan();
      i_Enable = 1'b0;
      i_Load   = 1'b0;
      i_LZB    = 1'b0;
      step();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      i_Rst_n = 1'b0;
      repeat (3) step();
      i_Rst_n = 1'b1;
      step();
      checks++; if (o_DigitSelect !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", o_DigitSelect); end
      checks++; if (o_Blank !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b expected 1", o_Blank); end
      checks++; if (o_BCD !== 4'd0) begin errors++; $display("FAIL reset_bcd: got %h expected 0", o_BCD); end
      checks++; if (o_FrameDone !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b expected 0", o_FrameDone); end

      // Scan 16'h4321 up to p=14 (digit 2 lit), then reset mid-cycle.
      i_Value  = 16'h4321;
      i_Load   = 1'b1;
      i_Enable = 1'b1;
      step();
      i_Load = 1'b0;
      checks++; if (o_BCD !== 4'h1) begin errors++; $display("FAIL reset_prescan_bcd: got %h expected 1", o_BCD); end
      repeat (14) step();
      checks++; if (o_DigitSelect !== 2'd2 || o_Blank !== 1'b0 || o_BCD !== 4'h3) begin
         errors++; $display("FAIL reset_prescan_p14: got sel=%0d blank=%b bcd=%h expected 2/0/3", o_DigitSelect, o_Blank, o_BCD);
      end
      #2 i_Rst_n = 1'b0;
      #1;
      checks++; if (o_DigitSelect !== 2'd0) begin errors++; $display("FAIL async_reset_sel: got %0d expected 0", o_DigitSelect); end
      checks++; if (o_Blank !== 1'b1) begin errors++; $display("FAIL async_reset_blank: got %b expected 1", o_Blank); end
      checks++; if (o_BCD !== 4'd0) begin errors++; $display("FAIL async_reset_bcd: got %h expected 0", o_BCD); end
      checks++; if (o_FrameDone !== 1'b0) begin errors++; $display("FAIL async_reset_fd: got %b expected 0", o_FrameDone); end
      @(negedge i_Clk);
      i_Rst_n = 1'b1;
      step();
      // Active register was cleared, so digits show 0.
      for (int p = 0; p < 12; p++) begin
         e_sel   = 2'((p % FRAME) / SLOT);
         e_blank = ((p % SLOT) >= DT);
         checks++; if (o_DigitSelect !== e_sel) begin errors++; $display("FAIL post_reset_sel p=%0d: got %0d expected %0d", p, o_DigitSelect, e_sel); end
         checks++; if (o_Blank !== e_blank) begin errors++; $display("FAIL post_reset_blank p=%0d: got %b expected %b", p, o_Blank, e_blank); end
         checks++; if (o_FrameDone !== 1'b0) begin errors++; $display("FAIL post_reset_fd p=%0d: got %b expected 0", p, o_FrameDone); end
         if (!e_blank) begin
            checks++; if (o_BCD !== 4'h0) begin errors++; $display("FAIL post_reset_bcd p=%0d: got %h expected 0", p, o_BCD); end
         end
         step();
      end
      stop_scan();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_scan();
      i_Value = 16'h1234;
      i_Load  = 1'b1;
      step();
      i_Load   = 1'b0;
      i_Value  = 16'h0000;
      i_Enable = 1'b1;
      step();
      e_val = 16'h1234;
      for (int p = 0; p <= 2 * FRAME; p++) begin
         e_sel   = 2'((p % FRAME) / SLOT);
         e_blank = ((p % SLOT) >= DT);
         e_fd    = (p > 0) && ((p % FRAME) == 0);
         e_bcd   = 4'(e_val >> (4 * e_sel));
         checks++; if (o_DigitSelect !== e_sel) begin errors++; $display("FAIL scan_sel p=%0d: got %0d expected %0d", p, o_DigitSelect, e_sel); end
         checks++; if (o_Blank !== e_blank) begin errors++; $display("FAIL scan_blank p=%0d: got %b expected %b", p, o_Blank, e_blank); end
         checks++; if (o_FrameDone !== e_fd) begin errors++; $display("FAIL scan_fd p=%0d: got %b expected %b", p, o_FrameDone, e_fd); end
         if (!e_blank) begin
            checks++; if (o_BCD !== e_bcd) begin errors++; $display("FAIL scan_bcd p=%0d: got %h expected %h", p, o_BCD, e_bcd); end
         end
         step();
      end
      stop_scan();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_midframe_load();
      i_Value  = 16'h1234;
      i_Load   = 1'b1;
      i_Enable = 1'b1;
      step();
      i_Load = 1'b0;
      for (int p = 0; p < 2 * FRAME; p++) begin
         e_sel   = 2'((p % FRAME) / SLOT);
         e_blank = ((p % SLOT) >= DT);
         e_val   = (p < FRAME) ? 16'h1234 : 16'h5678;
         e_bcd   = 4'(e_val >> (4 * e_sel));
         checks++; if (o_DigitSelect !== e_sel) begin errors++; $display("FAIL midload_sel p=%0d: got %0d expected %0d", p, o_DigitSelect, e_sel); end
         if (!e_blank) begin
            checks++; if (o_BCD !== e_bcd) begin errors++; $display("FAIL midload_bcd p=%0d: got %h expected %h", p, o_BCD, e_bcd); end
         end
         if (p == 7) begin
            i_Value = 16'h5678;
            i_Load  = 1'b1;
         end else begin
            i_Value = 16'h0000;
            i_Load  = 1'b0;
         end
         step();
      end
      stop_scan();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_lzb();
      i_LZB    = 1'b1;
      i_Value  = 16'h0070;
      i_Load   = 1'b1;
      i_Enable = 1'b1;
      step();
      i_Load = 1'b0;
      for (int p = 0; p < 2 * FRAME; p++) begin
         e_sel   = 2'((p % FRAME) / SLOT);
         // 0070: digits 3,2 are leading zeros; 0000: digits 3,2,1 are.
         e_blank = ((p % SLOT) >= DT) || ((p < FRAME) ? (e_sel >= 2'd2) : (e_sel >= 2'd1));
         e_val   = (p < FRAME) ? 16'h0070 : 16'h0000;
         e_bcd   = 4'(e_val >> (4 * e_sel));
         checks++; if (o_Blank !== e_blank) begin errors++; $display("FAIL lzb_blank p=%0d: got %b expected %b", p, o_Blank, e_blank); end
         if (!e_blank) begin
            checks++; if (o_BCD !== e_bcd) begin errors++; $display("FAIL lzb_bcd p=%0d: got %h expected %h", p, o_BCD, e_bcd); end
         end
         if (p == 0) begin
            i_Value = 16'h0000;
            i_Load  = 1'b1;
         end else begin
            i_Load = 1'b0;
         end
         step();
      end
      stop_scan();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_disable();
      i_Value  = 16'h1234;
      i_Load   = 1'b1;
      i_Enable = 1'b1;
      step();
      i_Load = 1'b0;
      // p=16 is the first dark cycle of digit 2.
      repeat (16) step();
      checks++; if (o_DigitSelect !== 2'd2 || o_Blank !== 1'b1) begin
         errors++; $display("FAIL disable_pre: got sel=%0d blank=%b expected 2/1", o_DigitSelect, o_Blank);
      end
      i_Enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (o_Blank !== 1'b1) begin errors++; $display("FAIL disable_blank k=%0d: got %b expected 1", k, o_Blank); end
         checks++; if (o_DigitSelect !== 2'd0) begin errors++; $display("FAIL disable_sel k=%0d: got %0d expected 0", k, o_DigitSelect); end
         checks++; if (o_FrameDone !== 1'b0) begin errors++; $display("FAIL disable_fd k=%0d: got %b expected 0", k, o_FrameDone); end
      end
      i_Enable = 1'b1;
      step();
      for (int p = 0; p <= int'(SLOT); p++) begin
         e_sel   = 2'((p % FRAME) / SLOT);
         e_blank = ((p % SLOT) >= DT);
         checks++; if (o_DigitSelect !== e_sel) begin errors++; $display("FAIL reenable_sel p=%0d: got %0d expected %0d", p, o_DigitSelect, e_sel); end
         checks++; if (o_Blank !== e_blank) begin errors++; $display("FAIL reenable_blank p=%0d: got %b expected %b", p, o_Blank, e_blank); end
         checks++; if (o_FrameDone !== 1'b0) begin errors++; $display("FAIL reenable_fd p=%0d: got %b expected 0", p, o_FrameDone); end
         step();
      end
      stop_scan();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_back_to_back();
      i_Value  = 16'h1234;
      i_Load   = 1'b1;
      i_Enable = 1'b1;
      step();
      i_Load = 1'b0;
      for (int p = 0; p < 3 * FRAME; p++) begin
         e_sel   = 2'((p % FRAME) / SLOT);
         e_blank = ((p % SLOT) >= DT);
         e_fd    = (p > 0) && ((p % FRAME) == 0);
         e_val   = (p < FRAME) ? 16'h1234 : ((p < 2 * FRAME) ? 16'h9999 : 16'h3333);
         e_bcd   = 4'(e_val >> (4 * e_sel));
         checks++; if (o_FrameDone !== e_fd) begin errors++; $display("FAIL b2b_fd p=%0d: got %b expected %b", p, o_FrameDone, e_fd); end
         if (!e_blank) begin
            checks++; if (o_BCD !== e_bcd) begin errors++; $display("FAIL b2b_bcd p=%0d: got %h expected %h", p, o_BCD, e_bcd); end
         end
         i_Load = 1'b1;
         case (p)
            5:       i_Value = 16'h1111;
            23:      i_Value = 16'h9999;  // wrap cycle, 1111 still pending
            30:      i_Value = 16'h2222;
            31:      i_Value = 16'h3333;
            default: i_Load  = 1'b0;
         endcase
         step();
      end
      stop_scan();
   endtask

   // ------------------------------------------------------------------------
   initial begin
      test_reset();
      test_scan();
      test_midframe_load();
      test_lzb();
      test_disable();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
